class_router_n: RTL and testbench

//   Parametrised successor of the transaction-layer class referee. Pops words from one

---
 rtl/class_router_n.sv | 122 ++++++++++++
 tb/tb_class_router_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_router_n.sv
// class_router_n: pops an upstream FIFO and steers each word to one of NUM_CH channel FIFOs by its class field.
// 2-entry buffer, registered pop/push; optional per-channel dispatch counters under DISPATCH_CNT_EN.
module class_router_n #(
   parameter int DATA_W    = 12,
   parameter int NUM_CH    = 4,
   parameter int CLASS_W   = 2,
   parameter int CLASS_LSB = 10,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              state,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    empty,
   input  logic                    almost_empty,
   output logic                    pop,
   input  logic [NUM_CH-1:0]       almost_full,
   output logic [NUM_CH-1:0]       push,
   output logic [DATA_W-1:0]       data_out
`ifdef DISPATCH_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] disp_cnt
`endif
);

   localparam logic [3:0] ST_INIT  = 4'b0001;
   localparam logic [3:0] ST_ACT_A = 4'b0100;
   localparam logic [3:0] ST_ACT_B = 4'b1000;

   logic [DATA_W-1:0]  buf_q [2];
   logic               rd_ptr;
   logic               wr_ptr;
   logic [1:0]         count;
   logic               pop_d;

   logic               is_init;
   logic               is_active;
   logic [DATA_W-1:0]  head;
   logic [CLASS_W-1:0] head_cls;
   logic               dispatch;
   logic               capture;
   logic [2:0]         pending;
   logic               space;
   logic               pop_nxt;

   assign is_init   = (state == ST_INIT);
   assign is_active = (state == ST_ACT_A) || (state == ST_ACT_B);
   assign head      = buf_q[rd_ptr];
   assign head_cls  = head[CLASS_LSB +: CLASS_W];

   // Only the head's own channel can stall it; younger words wait behind it.
   assign dispatch  = is_active && (count != 2'd0) && !almost_full[head_cls];
   assign capture   = pop_d && !is_init;

   // Words buffered plus both reads in flight must leave room for one more.
   assign pending   = 3'(count) + 3'(pop) + 3'(pop_d) - 3'(dispatch);
   assign space     = (pending < 3'd2);
   assign pop_nxt   = is_active && !empty && !(pop && almost_empty) && space;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pop      <= 1'b0;
         pop_d    <= 1'b0;
         push     <= '0;
         data_out <= '0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else if (is_init) begin
         pop      <= 1'b0;
         pop_d    <= 1'b0;
         push     <= '0;
         data_out <= '0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         pop   <= pop_nxt;
         pop_d <= pop;
         push  <= '0;
         if (dispatch) begin
            push[head_cls] <= 1'b1;
            data_out       <= head;
            rd_ptr         <= ~rd_ptr;
         end
         if (capture) begin
            wr_ptr <= ~wr_ptr;
         end
         count <= count + 2'(capture) - 2'(dispatch);
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         buf_q[wr_ptr] <= data_in;
      end
   end

   assert property (@(posedge clk) disable iff (reset) count != 2'd3);
   assert property (@(posedge clk) disable iff (reset)
                    (NUM_CH == (1 << CLASS_W)) && (CNT_W > 0) && (CLASS_LSB + CLASS_W <= DATA_W));

`ifdef DISPATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_CH];

   // Saturating: a counter parked at all-ones stays there until reset or INIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (is_init) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (dispatch && (cnt_q[head_cls] != '1)) begin
         cnt_q[head_cls] <= cnt_q[head_cls] + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign disp_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_class_router_n.sv
// Bench for class_router_n: upstream FIFO model, in-order scoreboard and directed corner cases plus random traffic.
// Counter checks are active only when DISPATCH_CNT_EN is defined (CNT_W=2 instance).
module tb_class_router_n;

   localparam int DW  = 12;
   localparam int NCH = 4;
   localparam int CW  = 2;
   localparam int CNW = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [3:0]     state = 4'b1000;
   logic [DW-1:0]  data_in = '0;
   logic           empty = 1'b1;
   logic           almost_empty = 1'b0;
   logic           pop;
   logic [NCH-1:0] almost_full = '0;
   logic [NCH-1:0] push;
   logic [DW-1:0]  data_out;
`ifdef DISPATCH_CNT_EN
   logic [NCH*CNW-1:0] disp_cnt;
   int                 cnt_m [NCH];
`endif

   logic [DW-1:0]  up_q [$];
   logic [DW-1:0]  exp_q [$];
   logic [3:0]     push_log [$];
   logic [DW-1:0]  last_out;
   logic [3:0]     af_prev;
   logic [3:0]     st_prev;
   logic           pop_seen;
   int             n_pop;
   int             n_chk;
   int             n_pass;

   always #5 clk = ~clk;

   class_router_n #(
      .DATA_W(DW), .NUM_CH(NCH), .CLASS_W(CW), .CLASS_LSB(10), .CNT_W(CNW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .state(state),
      .data_in(data_in),
      .empty(empty),
      .almost_empty(almost_empty),
      .pop(pop),
      .almost_full(almost_full),
      .push(push),
      .data_out(data_out)
`ifdef DISPATCH_CNT_EN
      ,
      .disp_cnt(disp_cnt)
`endif
   );

   function automatic logic is_act(input logic [3:0] s);
      return (s == 4'b0100) || (s == 4'b1000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic upd_flags();
      empty        = (up_q.size() == 0);
      almost_empty = (up_q.size() == 1);
   endtask

   task automatic load(input logic [DW-1:0] w);
      up_q.push_back(w);
      upd_flags();
   endtask

   // One clock: upstream FIFO reaction, reference-model update and output checks.
   task automatic step();
      logic [DW-1:0] w;
      logic [1:0]    ch;
      af_prev = almost_full;
      st_prev = state;
      @(posedge clk);
      #1;
      if (pop_seen) begin
         chk("pop_nonempty", 32'(up_q.size() != 0), 32'd1);
         if (up_q.size() != 0) begin
            w = up_q.pop_front();
            data_in = w;
            exp_q.push_back(w);
         end
      end
      if (reset || st_prev == 4'b0001) begin
         exp_q.delete();
         last_out = '0;
`ifdef DISPATCH_CNT_EN
         for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
`endif
      end
      if (push != '0) begin
         push_log.push_back(push);
         if (exp_q.size() == 0) begin
            chk("push_spurious", 32'(push), 32'd0);
         end else begin
            w  = exp_q.pop_front();
            ch = w[DW-1 -: CW];
            chk("push_dat", 32'(data_out), 32'(w));
            chk("push_ch", 32'(push), 32'd1 << ch);
            chk("push_af_clear", 32'(af_prev[ch]), 32'd0);
            chk("push_active", 32'(is_act(st_prev)), 32'd1);
            last_out = w;
`ifdef DISPATCH_CNT_EN
            if (cnt_m[ch] < 3) cnt_m[ch]++;
`endif
         end
      end else begin
         chk("dout_hold", 32'(data_out), 32'(last_out));
      end
      if (pop) begin
         n_pop++;
         chk("pop_active", 32'(is_act(st_prev)), 32'd1);
      end
`ifdef DISPATCH_CNT_EN
      begin
         logic [NCH*CNW-1:0] ev;
         for (int i = 0; i < NCH; i++) ev[i*CNW +: CNW] = 2'(cnt_m[i]);
         chk("disp_cnt", 32'(disp_cnt), 32'(ev));
      end
`endif
      pop_seen = pop;
      upd_flags();
   endtask

   task automatic drain(input string tag);
      logic done;
      done = 1'b0;
      almost_full = '0;
      state = 4'b1000;
      for (int i = 0; i < 300 && !done; i++) begin
         step();
         done = (up_q.size() == 0) && (exp_q.size() == 0) && !pop_seen;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic clr_logs();
      push_log.delete();
      n_pop = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] pause_tab [3];
      int         r;
      n_chk = 0; n_pass = 0; n_pop = 0;
      pop_seen = 1'b0; last_out = '0;
      af_prev = '0; st_prev = 4'b1000;
      pause_tab[0] = 4'b0010; pause_tab[1] = 4'b0000; pause_tab[2] = 4'b0110;
`ifdef DISPATCH_CNT_EN
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
`endif

      // reset state
      #1 reset = 1'b1;
      #1;
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_push", 32'(push), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      step();
      step();
      reset = 1'b0;

      // four classes back to back
      state = 4'b0100;
      clr_logs();
      load(12'h000); load(12'h401); load(12'h802); load(12'hC03);
      repeat (20) step();
      chk("t2_npush", 32'(push_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < push_log.size()) chk("t2_push_vec", 32'(push_log[i]), 32'd1 << i);
      chk("t2_pops", 32'(n_pop), 32'd4);

      // head-of-line blocking
      state = 4'b1000;
      almost_full = 4'b0100;
      clr_logs();
      load(12'h805); load(12'h006);
      repeat (12) step();
      chk("t3_blocked", 32'(push_log.size()), 32'd0);
      almost_full = 4'b0000;
      repeat (8) step();
      chk("t3_npush", 32'(push_log.size()), 32'd2);
      if (push_log.size() == 2) begin
         chk("t3_first", 32'(push_log[0]), 32'h4);
         chk("t3_second", 32'(push_log[1]), 32'h1);
      end

      // single-word FIFO
      clr_logs();
      load(12'hC07);
      repeat (10) step();
      chk("t4_pops", 32'(n_pop), 32'd1);
      chk("t4_push", 32'(push_log.size()), 32'd1);

      // pause with a read in flight
      clr_logs();
      load(12'h40A);
      for (int i = 0; i < 10 && !pop; i++) step();
      chk("t5_pop_seen", 32'(pop), 32'd1);
      step();
      state = 4'b0010;
      repeat (5) step();
      chk("t5_paused", 32'(push_log.size()), 32'd0);
      state = 4'b1000;
      step();
      chk("t5_resume", 32'(push), 32'h2);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if (up_q.size() < 6 && $urandom_range(0, 2) != 0) load(DW'($urandom_range(0, 4095)));
         if ($urandom_range(0, 3) == 0) almost_full = 4'($urandom) & 4'($urandom);
         r = $urandom_range(0, 9);
         state = (r < 7) ? (r[0] ? 4'b0100 : 4'b1000) : pause_tab[r-7];
         step();
      end
      drain("rand_drain");

      // INIT discards buffered words
      almost_full = 4'b1111;
      load(12'h111); load(12'h512); load(12'h923);
      repeat (8) step();
      state = 4'b0001;
      step();
      chk("init_dout", 32'(data_out), 32'd0);
      chk("init_pop", 32'(pop), 32'd0);
      chk("init_push", 32'(push), 32'd0);
      clr_logs();
      drain("init_drain");
      chk("init_discard", 32'(push_log.size()), 32'd1);

`ifdef DISPATCH_CNT_EN
      state = 4'b0001;
      step();
      for (int i = 0; i < 5; i++) load(12'h400 | DW'(i));
      drain("cnt_drain");
      chk("cnt_sat", 32'(disp_cnt[3:2]), 32'd3);
      state = 4'b0001;
      step();
      chk("cnt_init", 32'(disp_cnt), 32'd0);
      state = 4'b1000;
`endif

      // asynchronous reset mid-traffic
      state = 4'b1000;
      almost_full = '0;
      for (int i = 0; i < 5; i++) load(12'h7F1 + DW'(i));
      repeat (6) step();
      #3;
      reset = 1'b1;
      pop_seen = 1'b0;
      #1;
      chk("mid_rst_pop", 32'(pop), 32'd0);
      chk("mid_rst_push", 32'(push), 32'd0);
      chk("mid_rst_dout", 32'(data_out), 32'd0);
      step();
      step();
      reset = 1'b0;
      up_q.delete();
      exp_q.delete();
      upd_flags();
      load(12'hA5A); load(12'h3C3);
      drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
